// File: rtl/rob_mc_if.sv
// rob_mc_if: allocate, CDB snoop and commit bundle of the reorder buffer.
// master = scheduler/CDB/commit side, slave = rob_mc.
interface rob_mc_if #(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int VAL_W     = 32,
  parameter int CDB_PORTS = 2
);
  logic                         alloc_valid;
  logic                         alloc_ready;
  logic [1:0]                   alloc_itype;
  logic [4:0]                   alloc_dest;
  logic [IDX_W-1:0]             alloc_tag;
  logic [CDB_PORTS-1:0]         cdb_valid;
  logic [CDB_PORTS*IDX_W-1:0]   cdb_tag;
  logic [CDB_PORTS*VAL_W-1:0]   cdb_value;
  logic [CDB_PORTS-1:0]         cdb_mispredict;
  logic [1:0]                   commit_valid;
  logic [1:0]                   commit_en;
  logic [1:0][1:0]              commit_itype;
  logic [1:0][4:0]              commit_dest;
  logic [1:0][VAL_W-1:0]        commit_value;
  logic [1:0]                   commit_mispredict;
  logic                         flush;
  logic [IDX_W:0]               count;
  logic                         full;
  logic                         empty;

  modport master (
    output alloc_valid, alloc_itype, alloc_dest,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
    output commit_en,
    input  alloc_ready, alloc_tag,
    input  commit_valid, commit_itype, commit_dest,
    input  commit_value, commit_mispredict,
    input  flush, count, full, empty
  );

  modport slave (
    input  alloc_valid, alloc_itype, alloc_dest,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
    input  commit_en,
    output alloc_ready, alloc_tag,
    output commit_valid, commit_itype, commit_dest,
    output commit_value, commit_mispredict,
    output flush, count, full, empty
  );
endinterface

// File: rtl/rob_mc.sv
// rob_mc: multi-CDB reorder buffer, one alloc/cycle, 1 or 2 commits/cycle.
// Ports: clk, reset (async high), bus (rob_mc_if.slave). Macro ROB_DUAL_COMMIT_EN.
module rob_mc #(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int VAL_W     = 32,
  parameter int CDB_PORTS = 2
) (
  input logic   clk,
  input logic   reset,
  rob_mc_if.slave bus
);

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_ready;
  logic [DEPTH-1:0] e_misp;
  logic [1:0]       e_itype [DEPTH];
  logic [4:0]       e_dest  [DEPTH];
  logic [VAL_W-1:0] e_value [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W-1:0] h1;
  logic [IDX_W:0]   count;
  logic             flush_q;

  logic full_w;
  logic empty_w;
  logic cv0;
  logic cv1;
  logic c0;
  logic c1;
  logic head_bad;
  logic flush_now;
  logic fire;

  assign h1       = head + IDX_W'(1);
  assign full_w   = (count == (IDX_W+1)'(DEPTH));
  assign empty_w  = (count == '0);
  assign cv0      = !empty_w && e_ready[head];
  assign head_bad = (e_itype[head] == 2'b00) && e_misp[head];
  assign c0       = cv0 && bus.commit_en[0];
  // A mispredicted branch retiring at head wipes the whole buffer.
  assign flush_now = c0 && head_bad;
  assign bus.alloc_ready = !full_w && !flush_now;
  assign fire = bus.alloc_valid && bus.alloc_ready;

`ifdef ROB_DUAL_COMMIT_EN
  // Slot 1 never retires behind a mispredicted branch.
  assign cv1 = (count >= (IDX_W+1)'(2)) && e_ready[h1] && !head_bad;
  assign c1  = c0 && cv1 && bus.commit_en[1];
  assign bus.commit_itype[1]      = e_itype[h1];
  assign bus.commit_dest[1]       = e_dest[h1];
  assign bus.commit_value[1]      = e_value[h1];
  assign bus.commit_mispredict[1] = e_misp[h1];
`else
  logic unused_en1;
  assign unused_en1 = bus.commit_en[1];
  assign cv1 = 1'b0;
  assign c1  = 1'b0;
  assign bus.commit_itype[1]      = '0;
  assign bus.commit_dest[1]       = '0;
  assign bus.commit_value[1]      = '0;
  assign bus.commit_mispredict[1] = 1'b0;
`endif

  assign bus.commit_valid         = {cv1, cv0};
  assign bus.commit_itype[0]      = e_itype[head];
  assign bus.commit_dest[0]       = e_dest[head];
  assign bus.commit_value[0]      = e_value[head];
  assign bus.commit_mispredict[0] = e_misp[head];

  assign bus.alloc_tag = tail;
  assign bus.flush     = flush_q;
  assign bus.count     = count;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      flush_q <= 1'b0;
      e_valid <= '0;
      e_ready <= '0;
      e_misp  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_itype[i] <= '0;
        e_dest[i]  <= '0;
        e_value[i] <= '0;
      end
    end else if (flush_now) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      flush_q <= 1'b1;
      e_valid <= '0;
      e_ready <= '0;
    end else begin
      flush_q <= 1'b0;
      // Later ports are written last, so the highest port wins a tag clash.
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (bus.cdb_valid[p] &&
            e_valid[bus.cdb_tag[p*IDX_W +: IDX_W]] &&
            e_itype[bus.cdb_tag[p*IDX_W +: IDX_W]] != 2'b01) begin
          e_ready[bus.cdb_tag[p*IDX_W +: IDX_W]] <= 1'b1;
          if (e_itype[bus.cdb_tag[p*IDX_W +: IDX_W]] == 2'b00)
            e_misp[bus.cdb_tag[p*IDX_W +: IDX_W]] <= bus.cdb_mispredict[p];
          else
            e_value[bus.cdb_tag[p*IDX_W +: IDX_W]] <=
              bus.cdb_value[p*VAL_W +: VAL_W];
        end
      end
      if (c0) begin
        e_valid[head] <= 1'b0;
        e_ready[head] <= 1'b0;
      end
      if (c1) begin
        e_valid[h1] <= 1'b0;
        e_ready[h1] <= 1'b0;
      end
      // tail never aliases a retiring slot: full blocks alloc.
      if (fire) begin
        e_valid[tail] <= 1'b1;
        e_ready[tail] <= (bus.alloc_itype == 2'b01);
        e_itype[tail] <= bus.alloc_itype;
        e_dest[tail]  <= bus.alloc_dest;
        e_value[tail] <= '0;
        e_misp[tail]  <= 1'b0;
        tail          <= tail + IDX_W'(1);
      end
      head  <= head + IDX_W'(c0) + IDX_W'(c1);
      count <= count + (IDX_W+1)'(fire)
                     - (IDX_W+1)'(c0)
                     - (IDX_W+1)'(c1);
    end
  end

endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc: directed self-checking bench for rob_mc.
// Works with and without ROB_DUAL_COMMIT_EN.
module tb_rob_mc;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int VAL_W = 32;
  localparam int CDB_PORTS = 2;
`ifdef ROB_DUAL_COMMIT_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int fails = 0;

  rob_mc_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .VAL_W(VAL_W),
              .CDB_PORTS(CDB_PORTS)) bus ();

  rob_mc #(.DEPTH(DEPTH), .IDX_W(IDX_W), .VAL_W(VAL_W),
           .CDB_PORTS(CDB_PORTS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid    = 1'b0;
    bus.alloc_itype    = 2'b11;
    bus.alloc_dest     = 5'd0;
    bus.cdb_valid      = '0;
    bus.cdb_tag        = '0;
    bus.cdb_value      = '0;
    bus.cdb_mispredict = '0;
    bus.commit_en      = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    #1 reset = 1'b1;
    #1;
    chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    chk("rst_alloc_tag", 64'(bus.alloc_tag), 64'd0);
    chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // CDB to an unallocated slot is ignored
    bus.cdb_valid = 2'b01;
    bus.cdb_tag   = {4'd0, 4'd9};
    bus.cdb_value = {32'd0, 32'h99};
    tick();
    idle();
    #1;
    chk("cdb_inv_ready9", 64'(dut.e_ready[9]), 64'd0);
    chk("cdb_inv_value9", 64'(dut.e_value[9]), 64'd0);

    // Fill with 16 ALU entries
    for (int i = 0; i < 16; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_itype = 2'b11;
      bus.alloc_dest  = 5'(i);
      #1;
      chk($sformatf("fill_tag%0d", i), 64'(bus.alloc_tag), 64'(i));
      tick();
    end
    idle();
    #1;
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_alloc_ready", 64'(bus.alloc_ready), 64'd0);
    chk("fill_count", 64'(bus.count), 64'd16);
    chk("fill_cv_none", 64'(bus.commit_valid), 64'd0);

    // Same tag on both ports: port 1 wins
    bus.cdb_valid = 2'b11;
    bus.cdb_tag   = {4'd3, 4'd3};
    bus.cdb_value = {32'hBB, 32'hAA};
    tick();
    idle();
    #1;
    chk("clash_value3", 64'(dut.e_value[3]), 64'hBB);
    chk("clash_ready3", 64'(dut.e_ready[3]), 64'd1);
    chk("clash_cv", 64'(bus.commit_valid), 64'd0);

    // Entries 0 and 1 complete
    bus.cdb_valid = 2'b11;
    bus.cdb_tag   = {4'd1, 4'd0};
    bus.cdb_value = {32'h11, 32'h10};
    tick();
    idle();
    #1;
    chk("c01_cv", 64'(bus.commit_valid), DUAL ? 64'd3 : 64'd1);
    chk("c01_val0", 64'(bus.commit_value[0]), 64'h10);
    chk("c01_dest0", 64'(bus.commit_dest[0]), 64'd0);
    chk("c01_val1", 64'(bus.commit_value[1]), DUAL ? 64'h11 : 64'h0);

    // Full with commit and alloc together: alloc rejected
    bus.commit_en   = 2'b11;
    bus.alloc_valid = 1'b1;
    bus.alloc_itype = 2'b11;
    bus.alloc_dest  = 5'd20;
    #1;
    chk("full_commit_ar", 64'(bus.alloc_ready), 64'd0);
    tick();
    bus.commit_en = 2'b00;
    #1;
    chk("after_commit_count", 64'(bus.count), DUAL ? 64'd14 : 64'd15);
    chk("wrap_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    chk("wrap_alloc_tag", 64'(bus.alloc_tag), 64'd0);
    tick();
    idle();
    #1;
    chk("wrap_count", 64'(bus.count), DUAL ? 64'd15 : 64'd16);
    chk("wrap_cv0", 64'(bus.commit_valid[0]), DUAL ? 64'd0 : 64'd1);

    // Reset mid-operation
    reset = 1'b1;
    #1;
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_cv", 64'(bus.commit_valid), 64'd0);
    chk("midrst_flush", 64'(bus.flush), 64'd0);
    chk("midrst_empty", 64'(bus.empty), 64'd1);
    tick();
    reset = 1'b0;

    // Store is ready at allocation
    bus.alloc_valid = 1'b1;
    bus.alloc_itype = 2'b01;
    bus.alloc_dest  = 5'd7;
    #1;
    chk("st_tag", 64'(bus.alloc_tag), 64'd0);
    chk("st_cv_empty", 64'(bus.commit_valid), 64'd0);
    tick();
    idle();
    #1;
    chk("st_cv", 64'(bus.commit_valid), 64'd1);
    chk("st_itype", 64'(bus.commit_itype[0]), 64'd1);
    chk("st_dest", 64'(bus.commit_dest[0]), 64'd7);
    bus.commit_en = 2'b01;
    tick();
    idle();
    #1;
    chk("st_empty", 64'(bus.empty), 64'd1);
    chk("st_count", 64'(bus.count), 64'd0);
    do_reset();

    // Mispredicted branch flushes
    bus.alloc_valid = 1'b1;
    bus.alloc_itype = 2'b00;
    bus.alloc_dest  = 5'd0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      bus.alloc_itype = 2'b11;
      bus.alloc_dest  = 5'(i);
      tick();
    end
    idle();
    bus.cdb_valid      = 2'b11;
    bus.cdb_tag        = {4'd1, 4'd0};
    bus.cdb_value      = {32'h77, 32'h0};
    bus.cdb_mispredict = 2'b01;
    tick();
    idle();
    #1;
    chk("br_count", 64'(bus.count), 64'd5);
    chk("br_cv", 64'(bus.commit_valid), 64'd1);
    chk("br_misp", 64'(bus.commit_mispredict[0]), 64'd1);
    chk("br_ar_pre", 64'(bus.alloc_ready), 64'd1);
    bus.commit_en   = 2'b11;
    bus.alloc_valid = 1'b1;
    bus.alloc_itype = 2'b11;
    #1;
    chk("br_ar_flush", 64'(bus.alloc_ready), 64'd0);
    tick();
    idle();
    #1;
    chk("br_flush", 64'(bus.flush), 64'd1);
    chk("br_count0", 64'(bus.count), 64'd0);
    chk("br_tag0", 64'(bus.alloc_tag), 64'd0);
    chk("br_empty", 64'(bus.empty), 64'd1);
    tick();
    chk("br_flush_drop", 64'(bus.flush), 64'd0);
    chk("br_cv_after", 64'(bus.commit_valid), 64'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
